xbar_wt_store: RTL and testbench
================================

XBAR_WT_STORE -- requirements
Module: xbar_wt_store

Interface
REQ-001 The block SHALL have parameter XBAR_SIZE, default 16: rows per crossbar, and weights per row.
REQ-002 The block SHALL have parameter WT_BITS, default 16: bits per weight.
REQ-003 The block SHALL have parameter NUM_XBAR, default 4: number of crossbars stored.
REQ-004 The block SHALL have derived widths XW = max(1, clog2(NUM_XBAR)) and RW = max(1, clog2(XBAR_SIZE)).
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-007 The block SHALL have port prog_start, input, width 1: request to program the crossbar selected by prog_xbar.
REQ-008 The block SHALL have port prog_xbar, input, width XW: crossbar index, sampled when prog_start is accepted.
REQ-009 The block SHALL have port prog_abort, input, width 1: cancel the programming session in progress.
REQ-010 The block SHALL have port wr_valid, input, width 1: wr_row holds a valid row.
REQ-011 The block SHALL have port wr_row, input, width XBAR_SIZE*WT_BITS: one row of weights; weight k is bits [k*WT_BITS +: WT_BITS].
REQ-012 The block SHALL have port wr_ready, output, width 1: the block accepts a row in this cycle.
REQ-013 The block SHALL have port prog_busy, output, width 1: the state is not IDLE.
REQ-014 The block SHALL have port prog_done, output, width 1: one-cycle pulse, registered, marking a successful commit.
REQ-015 The block SHALL have port rd_en, input, width 1: read request.
REQ-016 The block SHALL have port rd_xbar, input, width XW: crossbar index for the read.
REQ-017 The block SHALL have port rd_addr, input, width RW: row index for the read.
REQ-018 The block SHALL have port rd_data, output, width XBAR_SIZE*WT_BITS: the row that was read, registered; lane k is weight k.
REQ-019 The block SHALL have port rd_valid, output, width 1: rd_data is valid; registered.
REQ-020 The block SHALL have port active_bank, output, width NUM_XBAR: bit x is the currently active bank of crossbar x.

Function
REQ-021 Each crossbar SHALL have two banks (ping/pong) of XBAR_SIZE rows: the active bank serves reads and the shadow bank (the other one) takes writes.
REQ-022 The state machine SHALL have the states IDLE, PROG and COMMIT.
REQ-023 In IDLE, prog_start=1 SHALL latch prog_xbar into tgt, clear row_cnt and move to PROG; prog_start outside IDLE SHALL be ignored.
REQ-024 wr_ready SHALL be 1 only in PROG; a handshake is wr_valid && wr_ready && !prog_abort.
REQ-025 On a handshake, wr_row SHALL be written to row row_cnt of the shadow bank of tgt, and row_cnt SHALL increment.
REQ-026 A handshake with row_cnt = XBAR_SIZE-1 SHALL move the state to COMMIT.
REQ-027 wr_valid while wr_ready=0 SHALL cause no write.
REQ-028 In COMMIT (exactly one cycle), active_bank[tgt] SHALL toggle at the closing edge, the state SHALL return to IDLE, and prog_done SHALL be 1 in the following cycle only.
REQ-029 Latency: the last handshake is in cycle t, COMMIT in t+1, and prog_done=1 with the new bank visible in t+2.
REQ-030 prog_abort=1 in PROG SHALL move the state to IDLE: no bank toggle, no prog_done, and the row offered in that cycle is not written; the shadow contents are then don't-care.
REQ-031 prog_abort in IDLE or COMMIT SHALL be ignored; once COMMIT is entered, the commit completes.
REQ-032 prog_xbar >= NUM_XBAR SHALL be ignored and the state SHALL stay in IDLE.
REQ-033 Reads: when rd_en=1 in cycle t, rd_data and rd_valid SHALL be presented in cycle t+1, with rd_valid=1 for exactly one cycle per request.
REQ-034 A read SHALL use the active bank as sampled in cycle t; reads in t+1 (COMMIT) or earlier SHALL return the old bank, and reads in t+2 or later SHALL return the new one.
REQ-035 Reads and writes in the same cycle, including to the same crossbar, SHALL both complete with no stall, because they always hit different banks.
REQ-036 rd_xbar >= NUM_XBAR, or rd_addr >= XBAR_SIZE, SHALL return all-zero rd_data with rd_valid=1.
REQ-037 rd_en=0 SHALL give rd_valid=0 in the next cycle, and rd_data SHALL hold its previous value.
REQ-038 Back-to-back rd_en SHALL sustain one read per cycle.

Reset
REQ-039 reset=1 at a clock edge SHALL clear every weight in both banks to 0, set active_bank to 0, and set the state to IDLE, row_cnt to 0 and tgt to 0.
REQ-040 During reset, the outputs SHALL be wr_ready=0, prog_busy=0, prog_done=0, rd_valid=0 and rd_data=0.
REQ-041 reset SHALL take priority over every other input, including in the middle of PROG or COMMIT; no commit SHALL occur.

Verification (XBAR_SIZE=4, WT_BITS=8, NUM_XBAR=2)
REQ-042 Reset, then read xbar 1 row 2 -> rd_data=0 and rd_valid=1 one cycle later; active_bank=2'b00.
REQ-043 Program xbar 0 with rows 0x04030201, 0x08070605, 0x0C0B0A09 and 0x100F0E0D, with wr_valid gaps -> prog_done pulses at last handshake+2; active_bank=2'b01; reading row 3 gives 0x100F0E0D.
REQ-044 Read xbar 0 row 1 continuously while reprogramming it with 0xAA rows -> old 0x08070605 through the COMMIT cycle, then 0xAAAAAAAA from cycle t+2 on.
REQ-045 Abort after 2 rows of xbar 1 -> no prog_done, active_bank[1] unchanged, old data still read; a new prog_start is accepted on the next cycle.
REQ-046 Assert reset during PROG row 2 -> all outputs zero and all reads return 0; prog_start while busy, rd_addr=5 and prog_xbar=3 are each ignored or return zero as specified.

Source files
------------

// File: rtl/xbar_wt_store.sv
// Double-buffered weight store for a set of crossbars.
// Each crossbar keeps two banks of XBAR_SIZE rows. Reads always come from
// the active bank while a programming session fills the shadow bank; a
// one-cycle COMMIT flips the active bank once every row has been written.
// The weights are cleared by reset, so storage is register-based rather
// than block RAM.
module xbar_wt_store #(
  parameter int XBAR_SIZE = 16,
  parameter int WT_BITS   = 16,
  parameter int NUM_XBAR  = 4,
  localparam int XW    = (NUM_XBAR > 1) ? $clog2(NUM_XBAR) : 1,
  localparam int RW    = (XBAR_SIZE > 1) ? $clog2(XBAR_SIZE) : 1,
  localparam int ROW_W = XBAR_SIZE * WT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prog_start,
  input  logic [XW-1:0]       prog_xbar,
  input  logic                prog_abort,
  input  logic                wr_valid,
  input  logic [ROW_W-1:0]    wr_row,
  output logic                wr_ready,
  output logic                prog_busy,
  output logic                prog_done,
  input  logic                rd_en,
  input  logic [XW-1:0]       rd_xbar,
  input  logic [RW-1:0]       rd_addr,
  output logic [ROW_W-1:0]    rd_data,
  output logic                rd_valid,
  output logic [NUM_XBAR-1:0] active_bank
);

  typedef enum logic [1:0] {IDLE, PROG, COMMIT} state_t;

  state_t                state_reg;
  logic [XW-1:0]         tgt_reg;
  logic [RW-1:0]         row_cnt_reg;
  logic [NUM_XBAR-1:0]   active_bank_reg;
  logic                  prog_done_reg;
  logic [ROW_W-1:0]      rd_data_reg;
  logic                  rd_valid_reg;

  logic                  wr_fire;
  logic                  row_last;
  logic                  start_ok;
  logic                  rd_ok;
  logic [ROW_W-1:0]      xbar_row [NUM_XBAR];

  // An abort in the same cycle as an offered row wins: the row is dropped.
  assign wr_fire  = (state_reg == PROG) && wr_valid && !prog_abort;
  assign row_last = (row_cnt_reg == RW'(XBAR_SIZE - 1));
  assign start_ok = prog_start && ({1'b0, prog_xbar} < (XW + 1)'(NUM_XBAR));
  assign rd_ok    = ({1'b0, rd_xbar} < (XW + 1)'(NUM_XBAR)) &&
                    ({1'b0, rd_addr} < (RW + 1)'(XBAR_SIZE));

  assign wr_ready    = (state_reg == PROG);
  assign prog_busy   = (state_reg != IDLE);
  assign prog_done   = prog_done_reg;
  assign rd_data     = rd_data_reg;
  assign rd_valid    = rd_valid_reg;
  assign active_bank = active_bank_reg;

  // Session control: IDLE -> PROG (collect XBAR_SIZE rows) -> COMMIT (flip bank).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      tgt_reg         <= '0;
      row_cnt_reg     <= '0;
      active_bank_reg <= '0;
      prog_done_reg   <= 1'b0;
    end else begin
      prog_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            tgt_reg     <= prog_xbar;
            row_cnt_reg <= '0;
            state_reg   <= PROG;
          end
        end
        PROG: begin
          if (prog_abort) begin
            state_reg <= IDLE;
          end else if (wr_valid) begin
            row_cnt_reg <= row_cnt_reg + 1'b1;
            if (row_last) state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          active_bank_reg <= active_bank_reg ^ (NUM_XBAR'(1) << tgt_reg);
          prog_done_reg   <= 1'b1;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-crossbar ping/pong storage; writes land in the bank that is not active.
  for (genvar gi = 0; gi < NUM_XBAR; gi++) begin : g_xbar
    logic [ROW_W-1:0] bank_reg [2][XBAR_SIZE];

    // Clear both banks on reset; otherwise accept handshaken rows into the shadow bank.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int b = 0; b < 2; b++) begin
          for (int r = 0; r < XBAR_SIZE; r++) begin
            bank_reg[b][r] <= '0;
          end
        end
      end else if (wr_fire && (tgt_reg == XW'(gi))) begin
        bank_reg[~active_bank_reg[gi]][row_cnt_reg] <= wr_row;
      end
    end

    assign xbar_row[gi] = bank_reg[active_bank_reg[gi]][rd_addr];
  end

  // Registered read port: out-of-range requests still answer, with zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_data_reg <= rd_ok ? xbar_row[rd_xbar] : '0;
      end
    end
  end

endmodule

// File: tb/tb_xbar_wt_store.sv
// Directed bench for xbar_wt_store. The main instance uses the small
// 4x8-bit, two-crossbar configuration. At those widths prog_xbar (1 bit)
// and rd_addr (2 bits) cannot carry the values 3 and 5, so a second
// instance with 5 rows and 3 crossbars exercises the out-of-range cases.
module tb_xbar_wt_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance: XBAR_SIZE=4, WT_BITS=8, NUM_XBAR=2
  logic        reset;
  logic        prog_start;
  logic [0:0]  prog_xbar;
  logic        prog_abort;
  logic        wr_valid;
  logic [31:0] wr_row;
  logic        wr_ready;
  logic        prog_busy;
  logic        prog_done;
  logic        rd_en;
  logic [0:0]  rd_xbar;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  active_bank;

  xbar_wt_store #(.XBAR_SIZE(4), .WT_BITS(8), .NUM_XBAR(2)) dut (
    .clk(clk), .reset(reset),
    .prog_start(prog_start), .prog_xbar(prog_xbar), .prog_abort(prog_abort),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_ready(wr_ready),
    .prog_busy(prog_busy), .prog_done(prog_done),
    .rd_en(rd_en), .rd_xbar(rd_xbar), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .active_bank(active_bank)
  );

  // Second instance: XBAR_SIZE=5, WT_BITS=8, NUM_XBAR=3 (XW=2, RW=3)
  logic        prog_start2;
  logic [1:0]  prog_xbar2;
  logic        prog_abort2;
  logic        wr_valid2;
  logic [39:0] wr_row2;
  logic        wr_ready2;
  logic        prog_busy2;
  logic        prog_done2;
  logic        rd_en2;
  logic [1:0]  rd_xbar2;
  logic [2:0]  rd_addr2;
  logic [39:0] rd_data2;
  logic        rd_valid2;
  logic [2:0]  active_bank2;

  xbar_wt_store #(.XBAR_SIZE(5), .WT_BITS(8), .NUM_XBAR(3)) dut2 (
    .clk(clk), .reset(reset),
    .prog_start(prog_start2), .prog_xbar(prog_xbar2), .prog_abort(prog_abort2),
    .wr_valid(wr_valid2), .wr_row(wr_row2), .wr_ready(wr_ready2),
    .prog_busy(prog_busy2), .prog_done(prog_done2),
    .rd_en(rd_en2), .rd_xbar(rd_xbar2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .active_bank(active_bank2)
  );

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one row for a single cycle.
  task automatic write_row(input logic [31:0] data);
    wr_valid = 1'b1;
    wr_row   = data;
    tick();
    wr_valid = 1'b0;
  endtask

  // Single-cycle read request, checked one cycle later.
  task automatic do_read(input string tag, input logic x, input logic [1:0] a, input logic [31:0] expected);
    rd_en   = 1'b1;
    rd_xbar = x;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check({tag, "_data"}, 64'(rd_data), 64'(expected));
  endtask

  initial begin
    reset = 1'b1;
    prog_start = 1'b0; prog_xbar = '0; prog_abort = 1'b0;
    wr_valid = 1'b0; wr_row = '0;
    rd_en = 1'b0; rd_xbar = '0; rd_addr = '0;
    prog_start2 = 1'b0; prog_xbar2 = '0; prog_abort2 = 1'b0;
    wr_valid2 = 1'b0; wr_row2 = '0;
    rd_en2 = 1'b0; rd_xbar2 = '0; rd_addr2 = '0;

    // Outputs while reset is held
    tick(); tick();
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_busy", 64'(prog_busy), 64'd0);
    check("rst_done", 64'(prog_done), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_active", 64'(active_bank), 64'd0);
    reset = 1'b0;
    tick();

    // Read xbar 1 row 2 after reset
    do_read("post_rst_rd", 1'b1, 2'd2, 32'h0);
    check("post_rst_active", 64'(active_bank), 64'd0);
    tick();
    check("rd_idle_valid", 64'(rd_valid), 64'd0);

    // Program xbar 0 with gaps in wr_valid
    prog_start = 1'b1; prog_xbar = 1'b0;
    tick();
    prog_start = 1'b0;
    check("p0_busy", 64'(prog_busy), 64'd1);
    check("p0_wr_ready", 64'(wr_ready), 64'd1);
    write_row(32'h04030201);
    tick();
    write_row(32'h08070605);
    write_row(32'h0C0B0A09);
    tick();
    tick();
    write_row(32'h100F0E0D);   // last handshake in cycle t; now in t+1
    check("p0_commit_busy", 64'(prog_busy), 64'd1);
    check("p0_commit_wr_ready", 64'(wr_ready), 64'd0);
    check("p0_commit_done", 64'(prog_done), 64'd0);
    check("p0_commit_active", 64'(active_bank), 64'd0);
    tick();                    // cycle t+2
    check("p0_done", 64'(prog_done), 64'd1);
    check("p0_active", 64'(active_bank), 64'd1);
    check("p0_idle_busy", 64'(prog_busy), 64'd0);
    tick();
    check("p0_done_once", 64'(prog_done), 64'd0);
    do_read("p0_row3", 1'b0, 2'd3, 32'h100F0E0D);
    tick();
    check("hold_valid", 64'(rd_valid), 64'd0);
    check("hold_data", 64'(rd_data), 64'h100F0E0D);
    do_read("p0_row0", 1'b0, 2'd0, 32'h04030201);
    do_read("x1_untouched", 1'b1, 2'd3, 32'h0);

    // Reprogram xbar 0 with 0xAA rows while reading row 1 every cycle
    rd_en = 1'b1; rd_xbar = 1'b0; rd_addr = 2'd1;
    prog_start = 1'b1; prog_xbar = 1'b0;
    tick();
    prog_start = 1'b0;
    check("rw_start_data", 64'(rd_data), 64'h08070605);
    wr_valid = 1'b1; wr_row = 32'hAAAAAAAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rw_old_%0d", i), 64'(rd_data), 64'h08070605);
      check($sformatf("rw_valid_%0d", i), 64'(rd_valid), 64'd1);
    end
    wr_valid = 1'b0;           // now in COMMIT (t+1)
    tick();                    // t+2: data read in COMMIT is still old
    check("rw_commit_read_old", 64'(rd_data), 64'h08070605);
    check("rw_done", 64'(prog_done), 64'd1);
    check("rw_active", 64'(active_bank), 64'd0);
    tick();                    // data read in t+2
    check("rw_new_t2", 64'(rd_data), 64'hAAAAAAAA);
    tick();
    check("rw_new_t3", 64'(rd_data), 64'hAAAAAAAA);
    rd_en = 1'b0;
    tick();

    // Program xbar 1; a stray prog_start for xbar 0 mid-session is ignored
    prog_start = 1'b1; prog_xbar = 1'b1;
    tick();
    write_row(32'h11111111);
    prog_start = 1'b1; prog_xbar = 1'b0;
    write_row(32'h22222222);
    prog_start = 1'b0;
    write_row(32'h33333333);
    write_row(32'h44444444);
    tick();
    check("p1_done", 64'(prog_done), 64'd1);
    check("p1_active", 64'(active_bank), 64'd2);
    do_read("p1_row1", 1'b1, 2'd1, 32'h22222222);
    do_read("x0_kept", 1'b0, 2'd1, 32'hAAAAAAAA);

    // Abort after two rows of xbar 1
    prog_start = 1'b1; prog_xbar = 1'b1;
    tick();
    prog_start = 1'b0;
    write_row(32'hDEADBEEF);
    write_row(32'hDEADBEEF);
    prog_abort = 1'b1; wr_valid = 1'b1; wr_row = 32'hBADBADBA;
    tick();
    prog_abort = 1'b0; wr_valid = 1'b0;
    check("ab_busy", 64'(prog_busy), 64'd0);
    check("ab_wr_ready", 64'(wr_ready), 64'd0);
    check("ab_done", 64'(prog_done), 64'd0);
    prog_start = 1'b1; prog_xbar = 1'b1;
    tick();
    prog_start = 1'b0;
    check("ab_restart_busy", 64'(prog_busy), 64'd1);
    check("ab_done_late", 64'(prog_done), 64'd0);
    check("ab_active", 64'(active_bank), 64'd2);
    do_read("ab_old_row0", 1'b1, 2'd0, 32'h11111111);

    // Reset in the middle of PROG, while row 2 is offered
    write_row(32'h55555555);
    reset = 1'b1; wr_valid = 1'b1; wr_row = 32'h66666666;
    rd_en = 1'b1; rd_xbar = 1'b1; rd_addr = 2'd0;
    tick();
    wr_valid = 1'b0; rd_en = 1'b0;
    check("mr_busy", 64'(prog_busy), 64'd0);
    check("mr_wr_ready", 64'(wr_ready), 64'd0);
    check("mr_done", 64'(prog_done), 64'd0);
    check("mr_rd_valid", 64'(rd_valid), 64'd0);
    check("mr_rd_data", 64'(rd_data), 64'd0);
    check("mr_active", 64'(active_bank), 64'd0);
    reset = 1'b0;
    tick();
    check("mr_no_commit", 64'(prog_done), 64'd0);
    do_read("mr_x0_row1", 1'b0, 2'd1, 32'h0);
    do_read("mr_x1_row0", 1'b1, 2'd0, 32'h0);
    do_read("mr_x0_row3", 1'b0, 2'd3, 32'h0);

    // Out-of-range requests on the second instance
    prog_start2 = 1'b1; prog_xbar2 = 2'd3;
    tick();
    prog_start2 = 1'b0;
    check("oor_start_busy", 64'(prog_busy2), 64'd0);
    check("oor_start_ready", 64'(wr_ready2), 64'd0);
    prog_start2 = 1'b1; prog_xbar2 = 2'd2;
    tick();
    prog_start2 = 1'b0;
    check("inr_start_busy", 64'(prog_busy2), 64'd1);
    prog_abort2 = 1'b1;
    tick();
    prog_abort2 = 1'b0;
    check("inr_abort_busy", 64'(prog_busy2), 64'd0);
    rd_en2 = 1'b1; rd_xbar2 = 2'd0; rd_addr2 = 3'd5;
    tick();
    check("oor_addr_valid", 64'(rd_valid2), 64'd1);
    check("oor_addr_data", 64'(rd_data2), 64'd0);
    rd_xbar2 = 2'd3; rd_addr2 = 3'd0;
    tick();
    rd_en2 = 1'b0;
    check("oor_xbar_valid", 64'(rd_valid2), 64'd1);
    check("oor_xbar_data", 64'(rd_data2), 64'd0);
    check("oor_active", 64'(active_bank2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
